// File: rtl/ysyx_25030085_pc_pkg.sv
// Shared encodings for the PC unit: jump kinds, trace kinds, link registers.
package ysyx_25030085_pc_pkg;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_JAL  = 2'b01;
  localparam logic [1:0] JUMP_JALR = 2'b10;
  localparam logic [1:0] JUMP_RSVD = 2'b11;

  localparam logic [1:0] TRACE_NONE = 2'b00;
  localparam logic [1:0] TRACE_CALL = 2'b01;
  localparam logic [1:0] TRACE_RET  = 2'b10;
  localparam logic [1:0] TRACE_TRAP = 2'b11;

  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [4:0] REG_X1 = 5'd1;
  localparam logic [4:0] REG_X5 = 5'd5;

  // x1 (ra) and x5 (t0) are the RISC-V link registers used for call/return hints.
  function automatic logic is_link(input logic [4:0] r);
    return (r == REG_X1) || (r == REG_X5);
  endfunction

endpackage

// File: rtl/ysyx_25030085_ras.sv
// Circular return-address stack. Push on full overwrites the oldest entry;
// push+pop in the same cycle replaces the top. The caller never pops when empty.
module ysyx_25030085_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [XLEN-1:0] data_i,
  output logic [XLEN-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);
  import ysyx_25030085_pc_pkg::*;

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign top_o   = mem_q[ptr_q];

  // Next pointer/count and write slot for push, pop, or replace-top.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      wr_en = 1'b1;
    end else if (push_i) begin
      ptr_d  = ptr_q + PTR_W'(1);
      wr_idx = ptr_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (!full_o) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Control state: top pointer and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/ysyx_25030085_pc_unit.sv
// Program counter with next-PC selection, call/return tracking via a RAS,
// call-depth counter, sticky RAS flags and a registered trace port.
module ysyx_25030085_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter int              RAS_DEPTH = 8,
  parameter int              DEPTH_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  input  logic [31:0]        inst,
  input  logic [XLEN-1:0]    imm,
  input  logic [XLEN-1:0]    alu_result,
  input  logic [1:0]         jump,
  input  logic               branch,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vec,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    dnpc,
  output logic               trace_valid,
  output logic [1:0]         trace_kind,
  output logic [XLEN-1:0]    trace_pc,
  output logic [XLEN-1:0]    trace_dnpc,
  output logic [DEPTH_W-1:0] call_depth,
  output logic               ras_hit,
  output logic               ras_overflow,
  output logic               ras_underflow
);
  import ysyx_25030085_pc_pkg::*;

  logic [XLEN-1:0]    pc_q, pc_plus4;
  logic [4:0]         rd, rs1;
  logic               is_call, is_ret;
  logic               ras_push, ras_pop, ras_empty, ras_full;
  logic [XLEN-1:0]    ras_top;
  logic [1:0]         kind_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               tv_q, hit_q, hit_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [1:0]         tk_q;
  logic [XLEN-1:0]    tpc_q, tdnpc_q;

  // Pop (floor 0) then push (saturating), so call+return leaves depth unchanged.
  function automatic logic [DEPTH_W-1:0] depth_next(input logic [DEPTH_W-1:0] d,
                                                     input logic c, input logic r);
    logic [DEPTH_W-1:0] t;
    t = d;
    if (r && (t != '0)) t = t - DEPTH_W'(1);
    if (c && (t != '1)) t = t + DEPTH_W'(1);
    return t;
  endfunction

  assign pc_plus4 = pc_q + XLEN'(4);
  assign rd       = inst[11:7];
  assign rs1      = inst[19:15];

  // Next-PC priority: trap, jal, jalr, taken branch, sequential.
  always_comb begin
    dnpc = pc_plus4;
    if (trap_valid)              dnpc = trap_vec;
    else if (jump == JUMP_JAL)   dnpc = pc_q + imm;
    else if (jump == JUMP_JALR)  dnpc = {alu_result[XLEN-1:1], 1'b0};
    else if (branch)             dnpc = alu_result;
  end

  // Call/return decode; jalr linking through one link reg while reading the other is both.
  always_comb begin
    is_call = !trap_valid && ((jump == JUMP_JAL) || (jump == JUMP_JALR)) && is_link(rd);
    is_ret  = !trap_valid && (jump == JUMP_JALR) && is_link(rs1) &&
              ((rd == REG_X0) || (is_link(rd) && (rd != rs1)));
    kind_d  = TRACE_NONE;
    if (trap_valid)   kind_d = TRACE_TRAP;
    else if (is_call) kind_d = TRACE_CALL;
    else if (is_ret)  kind_d = TRACE_RET;
  end

  assign ras_push = advance && is_call;
  assign ras_pop  = advance && is_ret && !ras_empty;
  assign depth_d  = advance ? depth_next(depth_q, is_call, is_ret) : depth_q;
  assign hit_d    = ras_pop && (ras_top == dnpc);
  assign ovf_d    = ovf_q | (ras_push && !ras_pop && ras_full);
  assign unf_d    = unf_q | (advance && is_ret && ras_empty);

  ysyx_25030085_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_plus4),
    .top_o   (ras_top),
    .empty_o (ras_empty),
    .full_o  (ras_full)
  );

  // PC, depth and sticky flags advance only on commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VEC;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (advance) pc_q <= dnpc;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // One-cycle trace pulse for each committed call/return/trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv_q    <= 1'b0;
      tk_q    <= TRACE_NONE;
      tpc_q   <= '0;
      tdnpc_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      tv_q  <= advance && (kind_d != TRACE_NONE);
      tk_q  <= advance ? kind_d : TRACE_NONE;
      hit_q <= hit_d;
      if (advance && (kind_d != TRACE_NONE)) begin
        tpc_q   <= pc_q;
        tdnpc_q <= dnpc;
      end
    end
  end

  assign pc            = pc_q;
  assign call_depth    = depth_q;
  assign trace_valid   = tv_q;
  assign trace_kind    = tk_q;
  assign trace_pc      = tpc_q;
  assign trace_dnpc    = tdnpc_q;
  assign ras_hit       = hit_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule

// File: tb/tb_ysyx_25030085_pc_unit.sv
// Directed bench for the PC unit: sequential flow, call/return, RAS limits,
// traps, hold, next-PC priority and reset during activity.
module tb_ysyx_25030085_pc_unit;

  localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] RET_X1   = 32'h0000_8067;
  localparam logic [31:0] JALR_1_5 = 32'h0002_80E7;

  logic        clk = 1'b0;
  logic        rst, advance, branch, trap_valid;
  logic [31:0] inst, imm, alu_result, trap_vec;
  logic [1:0]  jump;
  logic [31:0] pc, dnpc, trace_pc, trace_dnpc;
  logic        trace_valid, ras_hit, ras_overflow, ras_underflow;
  logic [1:0]  trace_kind;
  logic [15:0] call_depth;

  int total = 0;
  int bad   = 0;
  logic [31:0] mpc;
  logic [31:0] stack[$];

  always #5 clk = ~clk;

  ysyx_25030085_pc_unit dut (
    .clk(clk), .rst(rst), .advance(advance), .inst(inst), .imm(imm),
    .alu_result(alu_result), .jump(jump), .branch(branch),
    .trap_valid(trap_valid), .trap_vec(trap_vec), .pc(pc), .dnpc(dnpc),
    .trace_valid(trace_valid), .trace_kind(trace_kind), .trace_pc(trace_pc),
    .trace_dnpc(trace_dnpc), .call_depth(call_depth), .ras_hit(ras_hit),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    advance = 1'b1; inst = 32'h0000_0013; imm = '0; alu_result = '0;
    jump = 2'b00; branch = 1'b0; trap_valid = 1'b0; trap_vec = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    total++; if (pc !== 32'h8000_0000) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h8000_0000); end
    total++; if (trace_valid !== 1'b0 || trace_kind !== 2'b00) begin bad++; $display("FAIL reset_trace got=%b/%b exp=0/00", trace_valid, trace_kind); end
    total++; if (call_depth !== 16'd0 || ras_hit !== 1'b0) begin bad++; $display("FAIL reset_depth got=%0d hit=%b exp=0/0", call_depth, ras_hit); end
    total++; if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", ras_overflow, ras_underflow); end
    total++; if (trace_pc !== 32'h0 || trace_dnpc !== 32'h0) begin bad++; $display("FAIL reset_tpc got=%h/%h exp=0/0", trace_pc, trace_dnpc); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h8000_0000; exp_pc[1] = 32'h8000_0004;
    exp_pc[2] = 32'h8000_0008; exp_pc[3] = 32'h8000_000C;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc, exp_pc[i]); end
      step();
    end
    total++; if (pc !== 32'h8000_0010) begin bad++; $display("FAIL seq_pc4 got=%h exp=%h", pc, 32'h8000_0010); end
  endtask

  task automatic test_call_ret();
    inst = JAL_X1; jump = 2'b01; imm = 32'h100;
    #1;
    total++; if (dnpc !== 32'h8000_0110) begin bad++; $display("FAIL jal_dnpc got=%h exp=%h", dnpc, 32'h8000_0110); end
    step();
    total++; if (pc !== 32'h8000_0110) begin bad++; $display("FAIL jal_pc got=%h exp=%h", pc, 32'h8000_0110); end
    total++; if (trace_valid !== 1'b1 || trace_kind !== 2'b01) begin bad++; $display("FAIL call_trace got=%b/%b exp=1/01", trace_valid, trace_kind); end
    total++; if (trace_pc !== 32'h8000_0010 || trace_dnpc !== 32'h8000_0110) begin bad++; $display("FAIL call_tpc got=%h/%h exp=80000010/80000110", trace_pc, trace_dnpc); end
    total++; if (call_depth !== 16'd1) begin bad++; $display("FAIL call_depth got=%0d exp=1", call_depth); end
    inst = RET_X1; jump = 2'b10; imm = '0; alu_result = 32'h8000_0015;
    step();
    total++; if (pc !== 32'h8000_0014) begin bad++; $display("FAIL ret_pc got=%h exp=%h", pc, 32'h8000_0014); end
    total++; if (trace_kind !== 2'b10 || ras_hit !== 1'b1 || trace_valid !== 1'b1) begin bad++; $display("FAIL ret_trace got=%b/%b hit=%b exp=1/10 hit=1", trace_valid, trace_kind, ras_hit); end
    total++; if (call_depth !== 16'd0) begin bad++; $display("FAIL ret_depth got=%0d exp=0", call_depth); end
    idle_inputs();
    step();
    total++; if (trace_valid !== 1'b0 || trace_kind !== 2'b00 || ras_hit !== 1'b0) begin bad++; $display("FAIL trace_pulse got=%b/%b/%b exp=0/00/0", trace_valid, trace_kind, ras_hit); end
    mpc = 32'h8000_0018;
  endtask

  task automatic test_ras_limits();
    logic exp_hit;
    logic [31:0] tgt;
    for (int i = 0; i < 9; i++) begin
      inst = JAL_X1; jump = 2'b01; imm = 32'd8;
      stack.push_back(mpc + 32'd4);
      if (stack.size() > 8) void'(stack.pop_front());
      mpc = mpc + 32'd8;
      step();
      total++; if (pc !== mpc) begin bad++; $display("FAIL ovf_call%0d_pc got=%h exp=%h", i, pc, mpc); end
    end
    total++; if (ras_overflow !== 1'b1 || call_depth !== 16'd9 || ras_underflow !== 1'b0) begin bad++; $display("FAIL ovf_state got=%b/%0d/%b exp=1/9/0", ras_overflow, call_depth, ras_underflow); end
    for (int i = 0; i < 10; i++) begin
      inst = RET_X1; jump = 2'b10; imm = '0;
      if (stack.size() > 0) begin tgt = stack.pop_back(); exp_hit = 1'b1; end
      else begin tgt = 32'h8000_3000; exp_hit = 1'b0; end
      alu_result = tgt;
      mpc = tgt;
      step();
      total++; if (pc !== mpc || ras_hit !== exp_hit) begin bad++; $display("FAIL ret%0d got=%h hit=%b exp=%h hit=%b", i, pc, ras_hit, mpc, exp_hit); end
      if (i == 7) begin
        total++; if (ras_underflow !== 1'b0) begin bad++; $display("FAIL unf_early got=%b exp=0", ras_underflow); end
      end
    end
    total++; if (ras_underflow !== 1'b1 || call_depth !== 16'd0 || ras_overflow !== 1'b1) begin bad++; $display("FAIL unf_state got=%b/%0d/%b exp=1/0/1", ras_underflow, call_depth, ras_overflow); end
  endtask

  task automatic test_trap_hold();
    logic [31:0] trap_from;
    trap_from = mpc;
    inst = JAL_X1; jump = 2'b01; imm = 32'h40; trap_valid = 1'b1; trap_vec = 32'h8000_1000;
    step();
    total++; if (pc !== 32'h8000_1000) begin bad++; $display("FAIL trap_pc got=%h exp=%h", pc, 32'h8000_1000); end
    total++; if (trace_kind !== 2'b11 || trace_pc !== trap_from || trace_dnpc !== 32'h8000_1000) begin bad++; $display("FAIL trap_trace got=%b %h/%h exp=11 %h/80001000", trace_kind, trace_pc, trace_dnpc, trap_from); end
    total++; if (call_depth !== 16'd0) begin bad++; $display("FAIL trap_depth got=%0d exp=0", call_depth); end
    trap_valid = 1'b0; advance = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h8000_1000 || trace_valid !== 1'b0 || call_depth !== 16'd0) begin bad++; $display("FAIL hold%0d got=%h tv=%b d=%0d exp=80001000 tv=0 d=0", i, pc, trace_valid, call_depth); end
    end
    advance = 1'b1;
  endtask

  task automatic test_dnpc_priority();
    advance = 1'b0; inst = 32'h0000_0013;
    jump = 2'b00; branch = 1'b1; alu_result = 32'h8000_0101; #1;
    total++; if (dnpc !== 32'h8000_0101) begin bad++; $display("FAIL br_dnpc got=%h exp=80000101", dnpc); end
    jump = 2'b10; #1;
    total++; if (dnpc !== 32'h8000_0100) begin bad++; $display("FAIL jalr_dnpc got=%h exp=80000100", dnpc); end
    jump = 2'b11; branch = 1'b0; #1;
    total++; if (dnpc !== 32'h8000_1004) begin bad++; $display("FAIL rsvd_dnpc got=%h exp=80001004", dnpc); end
    jump = 2'b01; imm = 32'h8000_0000; #1;
    total++; if (dnpc !== 32'h0000_1000) begin bad++; $display("FAIL wrap_dnpc got=%h exp=00001000", dnpc); end
    step();
    total++; if (pc !== 32'h8000_1000) begin bad++; $display("FAIL noadv_pc got=%h exp=80001000", pc); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    inst = JAL_X1; jump = 2'b01; imm = 32'h10;
    step();
    total++; if (pc !== 32'h8000_1010 || call_depth !== 16'd1) begin bad++; $display("FAIL b2b_call got=%h d=%0d exp=80001010 d=1", pc, call_depth); end
    inst = JALR_1_5; jump = 2'b10; imm = '0; alu_result = 32'h8000_2000;
    step();
    total++; if (pc !== 32'h8000_2000 || trace_kind !== 2'b01 || call_depth !== 16'd1 || ras_hit !== 1'b0) begin bad++; $display("FAIL both got=%h k=%b d=%0d hit=%b exp=80002000 k=01 d=1 hit=0", pc, trace_kind, call_depth, ras_hit); end
    inst = RET_X1; alu_result = 32'h8000_1014;
    step();
    total++; if (pc !== 32'h8000_1014 || ras_hit !== 1'b1 || call_depth !== 16'd0) begin bad++; $display("FAIL both_ret got=%h hit=%b d=%0d exp=80001014 hit=1 d=0", pc, ras_hit, call_depth); end
    idle_inputs();
  endtask

  task automatic test_reset_midflight();
    inst = JAL_X1; jump = 2'b01; imm = 32'h20;
    step();
    total++; if (trace_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", trace_valid); end
    idle_inputs();
    rst = 1'b1; #1;
    total++; if (trace_valid !== 1'b0 || pc !== 32'h8000_0000 || call_depth !== 16'd0 || ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin bad++; $display("FAIL mid_rst got tv=%b pc=%h d=%0d f=%b%b exp tv=0 pc=80000000 d=0 f=00", trace_valid, pc, call_depth, ras_overflow, ras_underflow); end
    step();
    rst = 1'b0;
    #1;
    total++; if (pc !== 32'h8000_0000 || trace_valid !== 1'b0) begin bad++; $display("FAIL mid_rel got=%h tv=%b exp=80000000 tv=0", pc, trace_valid); end
    step();
    total++; if (pc !== 32'h8000_0004) begin bad++; $display("FAIL mid_next got=%h exp=80000004", pc); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_call_ret();
    test_ras_limits();
    test_trap_hold();
    test_dnpc_priority();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
